// File: rtl/ela_field_source.sv
`default_nettype none
// ============================================================================
// Module  : ela_field_source
// Brief   : Streams one field from a sync-read SRAM, one row per req pulse.
// Revision: 1.0
// ============================================================================
module ela_field_source #(
    parameter int ROWS = 16,
    parameter int COLS = 128,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          req,
    output logic          ready,
    output logic [7:0]    in_data,
    output logic [AW-1:0] src_addr,
    input  logic [7:0]    src_rd,
    output logic [4:0]    row_idx,
    output logic          field_done,
    output logic          err
);

    localparam int CW = $clog2(COLS);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_load    = 3'd1;
    localparam logic [2:0] c_capture = 3'd2;
    localparam logic [2:0] c_armed   = 3'd3;
    localparam logic [2:0] c_stream  = 3'd4;
    localparam logic [2:0] c_done    = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_col;
    logic [7:0]    r_p0;
    logic          r_ready;
    logic [AW-1:0] r_src_addr;
    logic [4:0]    r_row_idx;
    logic          r_field_done;
    logic          r_err;
    logic [7:0]    w_in_data;

    logic          w_start_ok;
    logic          w_last_col;
    logic          w_pre_col;
    logic          w_last_row;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_next_base;

    assign w_start_ok  = start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last_col  = (r_col == CW'(COLS - 1));
    assign w_pre_col   = (r_col == CW'(COLS - 2));
    assign w_last_row  = (r_row_idx == 5'(ROWS - 1));
    assign w_base      = AW'(r_row_idx) << CW;
    assign w_next_base = AW'(r_row_idx + 5'd1) << CW;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle, c_done: if (start) w_next = c_load;
            c_load:         w_next = c_capture;
            c_capture:      w_next = c_armed;
            c_armed:        if (req) w_next = c_stream;
            c_stream: begin
                if (w_last_col) w_next = w_last_row ? c_done : c_capture;
            end
            default:        w_next = c_idle;
        endcase
    end

    always_comb begin
        w_in_data = 8'd0;
        case (r_state)
            c_armed:  w_in_data = r_p0;
            c_stream: w_in_data = src_rd;
            default:  w_in_data = 8'd0;
        endcase
    end

    // The next row's base is issued at col COLS-2 so its pixel 0 lands in
    // CAPTURE, letting back-to-back rows skip LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col        <= '0;
            r_p0         <= 8'd0;
            r_ready      <= 1'b0;
            r_src_addr   <= '0;
            r_row_idx    <= 5'd0;
            r_field_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_field_done <= 1'b0;
            r_err        <= (r_err && !w_start_ok) || (req && (r_state != c_armed));
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_row_idx  <= 5'd0;
                        r_src_addr <= '0;
                    end
                end
                c_capture: begin
                    r_p0       <= src_rd;
                    r_src_addr <= w_base + AW'(1);
                    r_ready    <= 1'b1;
                end
                c_armed: begin
                    if (req) begin
                        r_col      <= CW'(1);
                        r_src_addr <= w_base + AW'(2);
                    end
                end
                c_stream: begin
                    r_col <= r_col + CW'(1);
                    if (w_last_col) begin
                        if (w_last_row) begin
                            r_field_done <= 1'b1;
                            r_ready      <= 1'b0;
                        end else begin
                            r_row_idx  <= r_row_idx + 5'd1;
                            r_src_addr <= w_next_base + AW'(1);
                        end
                    end else if (w_pre_col) begin
                        r_src_addr <= w_next_base;
                    end else begin
                        r_src_addr <= w_base + AW'(r_col) + AW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready      = r_ready;
    assign in_data    = w_in_data;
    assign src_addr   = r_src_addr;
    assign row_idx    = r_row_idx;
    assign field_done = r_field_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ela_field_source.sv
`default_nettype none
// Directed bench for ela_field_source with a synchronous-read SRAM model.
module tb_ela_field_source;

    localparam int ROWS = 16;
    localparam int COLS = 128;
    localparam int AW   = 11;

    logic          clk;
    logic          rst;
    logic          start;
    logic          req;
    logic          ready;
    logic [7:0]    in_data;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_rd;
    logic [4:0]    row_idx;
    logic          field_done;
    logic          err;

    logic [7:0] mem [ROWS*COLS];
    int n_cmp;
    int n_err;
    int fd_cnt;

    ela_field_source #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .req        (req),
        .ready      (ready),
        .in_data    (in_data),
        .src_addr   (src_addr),
        .src_rd     (src_rd),
        .row_idx    (row_idx),
        .field_done (field_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) src_rd <= mem[src_addr];

    always @(negedge clk) if (field_done === 1'b1) fd_cnt++;

    function automatic logic [7:0] exp_pix(input int a);
        logic [10:0] x;
        x = a[10:0];
        return x[7:0] ^ {3'b000, x[10:8], 2'b00};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in an ARMED cycle; returns in the cycle carrying pixel npix-1.
    task automatic stream_row(input int row, input int npix);
        req = 1'b1;
        check_eq("row_idx", 32'(row_idx), 32'(row));
        check_eq("pix0", 32'(in_data), 32'(exp_pix(row*COLS)));
        tick;
        req = 1'b0;
        for (int k = 1; k < npix; k++) begin
            check_eq("pix", 32'(in_data), 32'(exp_pix(row*COLS + k)));
            if (k < npix - 1) tick;
        end
    endtask

    initial begin
        int gap;
        n_cmp  = 0;
        n_err  = 0;
        fd_cnt = 0;
        rst    = 1'b0;
        start  = 1'b0;
        req    = 1'b0;
        for (int i = 0; i < ROWS*COLS; i++) mem[i] = exp_pix(i);

        tick; tick;
        rst = 1'b1;
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_in_data", 32'(in_data), 32'd0);
        check_eq("rst_src_addr", 32'(src_addr), 32'd0);
        check_eq("rst_row_idx", 32'(row_idx), 32'd0);
        check_eq("rst_field_done", 32'(field_done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // First row: start at S, ready at S+3
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("load_ready", 32'(ready), 32'd0);
        check_eq("load_addr", 32'(src_addr), 32'd0);
        tick;
        check_eq("cap_ready", 32'(ready), 32'd0);
        tick;
        check_eq("armed_ready", 32'(ready), 32'd1);
        check_eq("armed_addr", 32'(src_addr), 32'd1);
        stream_row(0, COLS);

        // Back-to-back row 1 at C+129
        tick;
        check_eq("cap1_row_idx", 32'(row_idx), 32'd1);
        check_eq("cap1_in_data", 32'(in_data), 32'd0);
        check_eq("cap1_addr", 32'(src_addr), 32'(COLS + 1));
        check_eq("cap1_ready", 32'(ready), 32'd1);
        tick;
        stream_row(1, COLS);

        // Early req in CAPTURE before row 2
        tick;
        req = 1'b1;
        check_eq("pre_err", 32'(err), 32'd0);
        tick;
        req = 1'b0;
        check_eq("early_err", 32'(err), 32'd1);
        check_eq("early_p0", 32'(in_data), 32'(exp_pix(2*COLS)));
        tick; tick;
        check_eq("armed_hold_p0", 32'(in_data), 32'(exp_pix(2*COLS)));
        check_eq("armed_hold_addr", 32'(src_addr), 32'(2*COLS + 1));
        stream_row(2, COLS);

        // Rest of the field with random gaps
        for (int r = 3; r < ROWS; r++) begin
            tick; tick;
            gap = int'($urandom_range(0, 400));
            repeat (gap) tick;
            check_eq("gap_ready", 32'(ready), 32'd1);
            stream_row(r, COLS);
        end
        check_eq("last_pix_fd", 32'(field_done), 32'd0);
        check_eq("last_pix_ready", 32'(ready), 32'd1);
        tick;
        check_eq("done_fd", 32'(field_done), 32'd1);
        check_eq("done_ready", 32'(ready), 32'd0);
        check_eq("done_in_data", 32'(in_data), 32'd0);
        tick;
        check_eq("done_fd_clear", 32'(field_done), 32'd0);
        check_eq("done_err_sticky", 32'(err), 32'd1);
        repeat (3) tick;
        check_eq("fd_count", 32'(fd_cnt), 32'd1);

        // Restart from DONE
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("restart_err", 32'(err), 32'd0);
        check_eq("restart_row_idx", 32'(row_idx), 32'd0);
        check_eq("restart_addr", 32'(src_addr), 32'd0);
        tick;
        check_eq("restart_cap_ready", 32'(ready), 32'd0);
        tick;
        check_eq("restart_ready", 32'(ready), 32'd1);
        check_eq("restart_addr1", 32'(src_addr), 32'd1);
        stream_row(0, COLS);
        tick; tick;
        stream_row(1, COLS);
        tick; tick;
        stream_row(2, COLS);
        tick; tick;

        // Reset mid-stream at row 3 col 40
        stream_row(3, 41);
        rst = 1'b0;
        tick; tick;
        rst = 1'b1;
        check_eq("mid_rst_ready", 32'(ready), 32'd0);
        check_eq("mid_rst_in_data", 32'(in_data), 32'd0);
        check_eq("mid_rst_addr", 32'(src_addr), 32'd0);
        check_eq("mid_rst_row_idx", 32'(row_idx), 32'd0);
        check_eq("mid_rst_fd", 32'(field_done), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        repeat (5) tick;
        check_eq("idle_addr_hold", 32'(src_addr), 32'd0);
        check_eq("idle_ready_hold", 32'(ready), 32'd0);
        check_eq("idle_in_data", 32'(in_data), 32'd0);
        check_eq("fd_count_final", 32'(fd_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
